// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
// 31 x DATA_W register file (address 0 reads as zero) with two combinational
// read ports, one synchronous write port, and a per-register pending-write
// counter used to detect read-after-write hazards at issue time.
//
// Issue handshake: IssueEn acts as "valid" for a destination reservation and
// !IssueFull acts as "ready"; the reservation is taken only on a cycle where
// both hold. Upstream issue logic is expected to hold IssueEn low while Stall
// is high; this block does not gate IssueEn with Stall itself.
module regfile_scoreboard #(
    parameter int DATA_W = 16,
    parameter int NREG   = 32,
    parameter int CNT_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        RdAddr0,
    input  logic [4:0]        RdAddr1,
    input  logic              RdUse0,
    input  logic              RdUse1,
    output logic [DATA_W-1:0] RdData0,
    output logic [DATA_W-1:0] RdData1,
    output logic              Busy0,
    output logic              Busy1,
    output logic              Stall,
    input  logic              IssueEn,
    input  logic [4:0]        IssueAddr,
    output logic              IssueFull,
    input  logic              WrEn,
    input  logic [4:0]        WrAddr,
    input  logic [DATA_W-1:0] WrData,
    output logic              WbError
);

    localparam int              AW      = 5;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Address 0 has no storage; entries 1..NREG-1 only.
    logic [DATA_W-1:0] r_regs [1:NREG-1];
    logic [CNT_W-1:0]  r_cnt  [1:NREG-1];
    logic              r_wb_error;

    logic [CNT_W-1:0]  w_cnt_rd0, w_cnt_rd1, w_cnt_wr, w_cnt_iss;
    logic [CNT_W-1:0]  w_eff0, w_eff1;
    logic              w_byp0, w_byp1;
    logic              w_issue_full;
    logic [NREG-1:1]   w_inc, w_dec;

    // Counter lookups for every address consumer; address 0 always reads as 0.
    always_comb begin
        w_cnt_rd0 = '0;
        w_cnt_rd1 = '0;
        w_cnt_wr  = '0;
        w_cnt_iss = '0;
        if (RdAddr0 != '0)   w_cnt_rd0 = r_cnt[RdAddr0];
        if (RdAddr1 != '0)   w_cnt_rd1 = r_cnt[RdAddr1];
        if (WrAddr != '0)    w_cnt_wr  = r_cnt[WrAddr];
        if (IssueAddr != '0) w_cnt_iss = r_cnt[IssueAddr];
    end

    // Read ports with write-through bypass; a same-cycle write-back also
    // retires one pending count for the hazard check.
    always_comb begin
        w_byp0  = WrEn && (WrAddr == RdAddr0);
        w_byp1  = WrEn && (WrAddr == RdAddr1);
        RdData0 = '0;
        RdData1 = '0;
        if (RdAddr0 != '0) RdData0 = w_byp0 ? WrData : r_regs[RdAddr0];
        if (RdAddr1 != '0) RdData1 = w_byp1 ? WrData : r_regs[RdAddr1];
        w_eff0 = (w_byp0 && (w_cnt_rd0 != '0)) ? (w_cnt_rd0 - CNT_ONE) : w_cnt_rd0;
        w_eff1 = (w_byp1 && (w_cnt_rd1 != '0)) ? (w_cnt_rd1 - CNT_ONE) : w_cnt_rd1;
        Busy0  = (RdAddr0 != '0) && (w_eff0 != '0);
        Busy1  = (RdAddr1 != '0) && (w_eff1 != '0);
    end

    // Refuse an issue to a saturated counter unless a write-back frees a slot now.
    always_comb begin
        w_issue_full = IssueEn && (IssueAddr != '0) && (w_cnt_iss == CNT_MAX)
                       && !(WrEn && (WrAddr == IssueAddr));
        IssueFull    = w_issue_full;
        Stall        = (RdUse0 && Busy0) || (RdUse1 && Busy1) || w_issue_full;
    end

    // Per-register increment/decrement requests; decrement never goes below 0.
    always_comb begin
        w_inc = '0;
        w_dec = '0;
        for (int a = 1; a < NREG; a++) begin
            w_inc[a] = IssueEn && (IssueAddr == AW'(a)) && !w_issue_full;
            w_dec[a] = WrEn && (WrAddr == AW'(a)) && (r_cnt[a] != '0);
        end
    end

    // Pending counters: simultaneous inc and dec cancel.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int a = 1; a < NREG; a++) r_cnt[a] <= '0;
        end else begin
            for (int a = 1; a < NREG; a++) begin
                if (w_inc[a] && !w_dec[a])      r_cnt[a] <= r_cnt[a] + CNT_ONE;
                else if (w_dec[a] && !w_inc[a]) r_cnt[a] <= r_cnt[a] - CNT_ONE;
            end
        end
    end

    // Register array write port; writes to address 0 are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int a = 1; a < NREG; a++) r_regs[a] <= '0;
        end else if (WrEn && (WrAddr != '0)) begin
            r_regs[WrAddr] <= WrData;
        end
    end

    // Sticky flag for a write-back with no outstanding reservation.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb_error <= 1'b0;
        end else if (WrEn && (WrAddr != '0) && (w_cnt_wr == '0)) begin
            r_wb_error <= 1'b1;
        end
    end

    assign WbError = r_wb_error;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: per-cycle vector table plus a sweep
// of all read addresses straight after reset.
module tb_regfile_scoreboard;

  localparam int DATA_W = 16;

  logic              clk;
  logic              rst;
  logic [4:0]        RdAddr0, RdAddr1;
  logic              RdUse0, RdUse1;
  logic [DATA_W-1:0] RdData0, RdData1;
  logic              Busy0, Busy1, Stall;
  logic              IssueEn;
  logic [4:0]        IssueAddr;
  logic              IssueFull;
  logic              WrEn;
  logic [4:0]        WrAddr;
  logic [DATA_W-1:0] WrData;
  logic              WbError;

  int checks = 0;
  int errors = 0;

  regfile_scoreboard #(.DATA_W(DATA_W), .NREG(32), .CNT_W(2)) dut (
    .clk(clk), .rst(rst),
    .RdAddr0(RdAddr0), .RdAddr1(RdAddr1),
    .RdUse0(RdUse0), .RdUse1(RdUse1),
    .RdData0(RdData0), .RdData1(RdData1),
    .Busy0(Busy0), .Busy1(Busy1), .Stall(Stall),
    .IssueEn(IssueEn), .IssueAddr(IssueAddr), .IssueFull(IssueFull),
    .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
    .WbError(WbError)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [4:0]  a0;
    logic        u0;
    logic [4:0]  a1;
    logic        u1;
    logic        ie;
    logic [4:0]  ia;
    logic        we;
    logic [4:0]  wa;
    logic [15:0] wd;
    logic [15:0] e_rd0;
    logic [15:0] e_rd1;
    logic        e_b0;
    logic        e_b1;
    logic        e_stall;
    logic        e_full;
    logic        e_wberr;
  } vec_t;

  vec_t vec_q[$];

  task automatic add(input logic r, input logic [4:0] a0, input logic u0,
                     input logic [4:0] a1, input logic u1,
                     input logic ie, input logic [4:0] ia,
                     input logic we, input logic [4:0] wa, input logic [15:0] wd,
                     input logic [15:0] e_rd0, input logic [15:0] e_rd1,
                     input logic e_b0, input logic e_b1, input logic e_stall,
                     input logic e_full, input logic e_wberr);
    vec_t v;
    v.rst = r; v.a0 = a0; v.u0 = u0; v.a1 = a1; v.u1 = u1;
    v.ie = ie; v.ia = ia; v.we = we; v.wa = wa; v.wd = wd;
    v.e_rd0 = e_rd0; v.e_rd1 = e_rd1; v.e_b0 = e_b0; v.e_b1 = e_b1;
    v.e_stall = e_stall; v.e_full = e_full; v.e_wberr = e_wberr;
    vec_q.push_back(v);
  endtask

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; RdAddr0 = v.a0; RdUse0 = v.u0; RdAddr1 = v.a1; RdUse1 = v.u1;
    IssueEn = v.ie; IssueAddr = v.ia; WrEn = v.we; WrAddr = v.wa; WrData = v.wd;
  endtask

  initial begin
    rst = 1'b1; RdAddr0 = '0; RdAddr1 = '0; RdUse0 = 1'b0; RdUse1 = 1'b0;
    IssueEn = 1'b0; IssueAddr = '0; WrEn = 1'b0; WrAddr = '0; WrData = '0;

    //   rst a0 u0 a1 u1 ie ia we wa wd        rd0      rd1      b0 b1 st fu wb
    // basic write, bypass, r0 ignored (write with no reservation sets WbError)
    add(0, 5, 1, 0, 0, 0, 0, 1, 5, 16'hBEEF, 16'hBEEF, 16'h0000, 0, 0, 0, 0, 0);
    add(0, 0, 0, 5, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'hBEEF, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, 16'h1234, 16'h0000, 16'h0000, 0, 0, 0, 0, 1);
    add(0, 0, 1, 5, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'hBEEF, 0, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 1);
    add(0, 5, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 0);
    // issue r7, stall, resolve by write-back
    add(0, 7, 1, 0, 0, 1, 7, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 0);
    add(0, 7, 1, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 0, 1, 0, 0);
    add(0, 7, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0, 0, 0);
    add(0, 7, 1, 0, 0, 0, 0, 1, 7, 16'h00AA, 16'h00AA, 16'h0000, 0, 0, 0, 0, 0);
    add(0, 7, 1, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h00AA, 16'h0000, 0, 0, 0, 0, 0);
    // saturation of r3
    add(0, 0, 0, 3, 1, 1, 3, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 0);
    add(0, 0, 0, 3, 1, 1, 3, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1, 1, 0, 0);
    add(0, 0, 0, 3, 1, 1, 3, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1, 1, 0, 0);
    add(0, 0, 0, 3, 0, 1, 3, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1, 1, 1, 0);
    add(0, 0, 0, 3, 1, 1, 3, 1, 3, 16'h0033, 16'h0000, 16'h0033, 0, 1, 1, 0, 0);
    add(0, 0, 0, 3, 1, 0, 0, 1, 3, 16'h0044, 16'h0000, 16'h0044, 0, 1, 1, 0, 0);
    add(0, 0, 0, 3, 1, 0, 0, 1, 3, 16'h0055, 16'h0000, 16'h0055, 0, 1, 1, 0, 0);
    add(0, 0, 0, 3, 1, 0, 0, 1, 3, 16'h0066, 16'h0000, 16'h0066, 0, 0, 0, 0, 0);
    add(0, 0, 0, 3, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0066, 0, 0, 0, 0, 0);
    // simultaneous issue and write-back to r9 with count 1
    add(0, 9, 1, 0, 0, 1, 9, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 0);
    add(0, 9, 1, 0, 0, 1, 9, 1, 9, 16'h0999, 16'h0999, 16'h0000, 0, 0, 0, 0, 0);
    add(0, 9, 1, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0999, 16'h0000, 1, 0, 1, 0, 0);
    add(0, 9, 1, 0, 0, 0, 0, 1, 9, 16'h0900, 16'h0900, 16'h0000, 0, 0, 0, 0, 0);
    // mid-operation reset (issue during reset is dropped), then stray write-back
    add(0, 4, 1, 0, 0, 1, 4, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 0);
    add(0, 4, 1, 6, 1, 1, 6, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 0, 1, 0, 0);
    add(1, 4, 1, 6, 1, 1, 4, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 1, 1, 0, 0);
    add(0, 4, 1, 6, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 0);
    add(0, 4, 1, 0, 0, 0, 0, 1, 4, 16'h4444, 16'h4444, 16'h0000, 0, 0, 0, 0, 0);
    add(0, 4, 1, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h4444, 16'h0000, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1, 2, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 1);
    add(0, 2, 1, 0, 0, 0, 0, 1, 2, 16'h0002, 16'h0002, 16'h0000, 0, 0, 0, 0, 1);
    add(0, 2, 1, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0002, 16'h0000, 0, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 1);
    add(0, 2, 1, 4, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 0);

    // reset, then sweep every read address on both ports
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    RdUse0 = 1'b1;
    RdUse1 = 1'b1;
    for (int i = 0; i < 32; i++) begin
      RdAddr0 = 5'(i);
      RdAddr1 = 5'(31 - i);
      #1;
      chk("sweep_rd0",   i, 32'(RdData0), 32'h0);
      chk("sweep_rd1",   i, 32'(RdData1), 32'h0);
      chk("sweep_busy",  i, {30'h0, Busy1, Busy0}, 32'h0);
      chk("sweep_stall", i, 32'(Stall), 32'h0);
    end
    chk("reset_full",  0, 32'(IssueFull), 32'h0);
    chk("reset_wberr", 0, 32'(WbError), 32'h0);

    // per-cycle vector table: drive after the edge, check at the falling edge
    for (int k = 0; k < vec_q.size(); k++) begin
      @(posedge clk);
      #1;
      drive(vec_q[k]);
      @(negedge clk);
      chk("rd0",   k, 32'(RdData0),   32'(vec_q[k].e_rd0));
      chk("rd1",   k, 32'(RdData1),   32'(vec_q[k].e_rd1));
      chk("busy0", k, 32'(Busy0),     32'(vec_q[k].e_b0));
      chk("busy1", k, 32'(Busy1),     32'(vec_q[k].e_b1));
      chk("stall", k, 32'(Stall),     32'(vec_q[k].e_stall));
      chk("full",  k, 32'(IssueFull), 32'(vec_q[k].e_full));
      chk("wberr", k, 32'(WbError),   32'(vec_q[k].e_wberr));
    end

    @(posedge clk);
    #1;
    rst = 1'b0; IssueEn = 1'b0; WrEn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Register file and destination scoreboard for the MIPS16 datapath: 32 × 16-bit registers, two combinational read ports and one synchronous write port. The destination address selected by the rt/rd address mux enters at `IssueAddr` when an instruction issues. The same address returns at `WrAddr` when the result is written back. Per-register pending counters track outstanding writes, and `Stall` is raised when a source operand still has an outstanding producer. Register 0 is hardwired to zero.

## Interface
- `DATA_W`, default 16: register width.
- `NREG`, default 32: register count; address width is 5 (fixed, equals log2 of `NREG`).
- `CNT_W`, default 2: pending-counter width; maximum outstanding writes per register is 2^`CNT_W` − 1.

- `clk`  input  1  rising-edge clock, single clock domain.
- `rst`  input  1  synchronous, active-high reset.
- `RdAddr0`, `RdAddr1`  input  5  read addresses (rs, rt).
- `RdUse0`, `RdUse1`  input  1  the instruction actually sources this port.
- `RdData0`, `RdData1`  output  `DATA_W`  read data.
- `Busy0`, `Busy1`  output  1  the addressed register has an unresolved pending write.
- `Stall`  output  1  issue must be held.
- `IssueEn`  input  1  an instruction with a destination issues this cycle.
- `IssueAddr`  input  5  destination address from the rt/rd mux.
- `IssueFull`  output  1  the counter for `IssueAddr` is saturated; the issue is refused.
- `WrEn`  input  1  write-back valid.
- `WrAddr`  input  5  write-back destination.
- `WrData`  input  `DATA_W`  write-back data.
- `WbError`  output  1  sticky flag: a write-back arrived for a register with a pending count of 0.

## Operation
- **Storage:** `reg[1..31]` are `DATA_W`-bit flops. Address 0 is not stored. Reads of address 0 return 0, and writes or issues to address 0 are ignored.
- **Write:** at the clock edge, if `WrEn` is high and `WrAddr` ≠ 0, then `reg[WrAddr]` ← `WrData`.
- **Read (combinational), per port N:**
  - `RdAddrN` == 0 → 0.
  - Else if `WrEn` is high and `WrAddr` == `RdAddrN` → `WrData` (write-through bypass).
  - Else → `reg[RdAddrN]`.
- **Pending counter `cnt[a]`, for a = 1..31:**
  - `inc` = `IssueEn` && `IssueAddr` == a && !`IssueFull`.
  - `dec` = `WrEn` && `WrAddr` == a && `cnt[a]` ≠ 0.
  - `inc` only → +1. `dec` only → −1. Both → unchanged. Neither → unchanged.
- **`IssueFull`** = `IssueEn` && `IssueAddr` ≠ 0 && `cnt[IssueAddr]` == max && !(`WrEn` && `WrAddr` == `IssueAddr`). A simultaneous write-back frees a slot, so the issue is accepted in that case.
- **`BusyN`** = `RdAddrN` ≠ 0 && `eff[RdAddrN]` ≠ 0. Here `eff[a]` = `cnt[a]` − 1 when a write-back to a occurs this cycle, otherwise `cnt[a]`. A write-back in the current cycle therefore resolves its own hazard, consistent with the bypass.
- **`Stall`** = (`RdUse0` && `Busy0`) || (`RdUse1` && `Busy1`) || `IssueFull`.
- **`WbError`:** set at the edge when `WrEn` is high, `WrAddr` ≠ 0 and `cnt[WrAddr]` == 0. The write itself still occurs. Cleared only by `rst`.
- **No FSM beyond the counters.** The block does not gate `IssueEn` with `Stall`; the upstream issue logic holds `IssueEn` low while stalled. `IssueEn` asserted while `Busy` is high is still counted.

## Timing
- **Read path:** zero-latency and combinational (`RdAddr`/`WrEn`/`WrAddr`/`WrData` → `RdData`).
- **Write visibility:** a written value is visible the same cycle via the bypass, and from the array starting the next cycle.
- **Counter updates:** take effect at the next edge. `Busy` reflects a same-cycle write-back but never a same-cycle issue (an issue becomes visible from the next cycle).
- **Reset:** while `rst` is high at an edge, all `reg` ← 0, all `cnt` ← 0, and `WbError` ← 0. Reset has priority over the write, issue and write-back events of that cycle. After reset:
  - `RdData*` = 0.
  - `Busy*` = 0, `Stall` = 0, `IssueFull` = 0, `WbError` = 0.
- **Reset mid-operation:** all outstanding pending counts are discarded. A write-back that arrives after reset sets `WbError`.
- **Wrap-around:** counters never wrap. They saturate at max via `IssueFull` and stop at 0 via the `dec` guard.

## Test plan
- **Reset, then read all 32 addresses** → every `RdData` = 0, `Busy` = 0, `Stall` = 0.
- **Basic write:** write 0xBEEF to r5, read r5 on port 0 in the same cycle → 0xBEEF via bypass. Next cycle, read r5 on port 1 → 0xBEEF. Write 0x1234 to r0 → reading r0 returns 0.
- **Issue, stall, resolve:** issue r7, next cycle read r7 with `RdUse0` high → `Busy0` = 1, `Stall` = 1. Write-back r7 = 0x00AA in a later cycle → in that cycle `Busy0` = 0, `Stall` = 0, `RdData0` = 0x00AA.
- **Saturation:** issue r3 three times → count 3. A fourth issue → `IssueFull` = 1, `Stall` = 1, count stays 3. A fourth issue together with a write-back to r3 → accepted, count stays 3. Three write-backs then return `Busy` to 0.
- **Simultaneous issue and write-back to r9 with count 1** → count stays 1, `Busy` for r9 = 0 that cycle and 1 the next cycle.
- **Mid-operation reset:** issue r4 and r6, assert `rst` for one cycle → counts 0 and `Busy` = 0. A write-back to r4 afterwards → `WbError` = 1 and stays set until the next `rst`.
